iter_shift_unit: RTL and testbench

//  Multi-cycle, parametrised shift/rotate unit for the MIPS datapath.

---
 rtl/iter_shift_unit_pkg.sv | 18 +
 rtl/iter_shift_unit_if.sv | 41 ++++
 rtl/iter_shift_unit_step.sv | 42 ++++
 rtl/iter_shift_unit.sv | 107 ++++++++++
 tb/tb_iter_shift_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/iter_shift_unit_pkg.sv
// Shared types for the iterative shift/rotate unit.
// Operation codes and controller states.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA,
    SH_ROR
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

endpackage

// File: rtl/iter_shift_unit_if.sv
// Request/response bundle for the iterative shifter.
// master drives the request side, slave is the shifter.
interface iter_shift_unit_if
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);

  logic               start;
  logic               flush;
  shift_op_e          op;
  logic [WIDTH-1:0]   din;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   dout;

  modport master (
    output start,
    output flush,
    output op,
    output din,
    output shamt,
    input  busy,
    input  done,
    input  dout
  );

  modport slave (
    input  start,
    input  flush,
    input  op,
    input  din,
    input  shamt,
    output busy,
    output done,
    output dout
  );

endinterface

// File: rtl/iter_shift_unit_step.sv
// One iteration of the shifter: moves acc by k bits.
// Purely combinational; k is clamped to STEP.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   acc,
  input  shift_op_e          op,
  input  logic [SHAMT_W-1:0] k,
  output logic [WIDTH-1:0]   res
);

  localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W+1)'(STEP);

  logic [SHAMT_W-1:0] kk;
  logic [WIDTH-1:0]   rot;

  always_comb begin
    kk = k;
    if ({1'b0, k} > STEP_L) begin
      kk = STEP_L[SHAMT_W-1:0];
    end
  end

  // Rotate as a slice of the doubled word
  assign rot = WIDTH'({acc, acc} >> kk);

  always_comb begin
    res = acc;
    unique case (op)
      SH_SLL: res = acc << kk;
      SH_SRL: res = acc >> kk;
      SH_SRA: res = $signed(acc) >>> kk;
      SH_ROR: res = rot;
      default: res = acc;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit, STEP bits per cycle.
// FSM, counter and result register around shift_step.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input logic               clk,
  input logic               rst_n,
  iter_shift_unit_if.slave  bus
);

  localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W+1)'(STEP);

  state_e             state;
  state_e             nxt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] k;
  shift_op_e          op_q;
  logic [WIDTH-1:0]   dout_q;
  logic               load;
  logic               adv;
  logic               fin;

  always_comb begin
    k = STEP_L[SHAMT_W-1:0];
    if ({1'b0, cnt} < STEP_L) begin
      k = cnt;
    end
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc (acc),
    .op  (op_q),
    .k   (k),
    .res (acc_nxt)
  );

  always_comb begin
    nxt  = state;
    load = 1'b0;
    adv  = 1'b0;
    fin  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          nxt  = S_SHIFT;
          load = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bus.flush) begin
          nxt = S_IDLE;
        end else if (cnt == '0) begin
          nxt = S_DONE;
          fin = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      op_q   <= SH_SLL;
      dout_q <= '0;
    end else begin
      if (load) begin
        acc  <= bus.din;
        cnt  <= bus.shamt;
        op_q <= bus.op;
      end else if (adv) begin
        acc <= acc_nxt;
        cnt <= cnt - k;
      end
      if (fin) begin
        dout_q <= acc;
      end
    end
  end

  assign bus.busy = (state != S_IDLE);
  // A flush landing in the DONE cycle suppresses the pulse
  assign bus.done = (state == S_DONE) && !bus.flush;
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit, STEP=1 and STEP=4.
// Expected values are hand-computed constants.
module tb_iter_shift_unit;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic        flush = 1'b0;
  shift_op_e   op = SH_SLL;
  logic [31:0] din = '0;
  logic [4:0]  shamt = '0;

  int total = 0;
  int bad = 0;
  int ndone1 = 0;

  always #5 clk = ~clk;

  iter_shift_unit_if #(.WIDTH(32)) bus1();
  iter_shift_unit_if #(.WIDTH(32)) bus4();

  assign bus1.start = start1;
  assign bus1.flush = flush;
  assign bus1.op    = op;
  assign bus1.din   = din;
  assign bus1.shamt = shamt;
  assign bus4.start = start4;
  assign bus4.flush = flush;
  assign bus4.op    = op;
  assign bus4.din   = din;
  assign bus4.shamt = shamt;

  iter_shift_unit #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  iter_shift_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  always @(negedge clk) begin
    if (bus1.done) ndone1++;
  end

  function automatic logic get_busy(int u);
    return (u == 1) ? bus1.busy : bus4.busy;
  endfunction

  function automatic logic get_done(int u);
    return (u == 1) ? bus1.done : bus4.done;
  endfunction

  function automatic logic [31:0] get_dout(int u);
    return (u == 1) ? bus1.dout : bus4.dout;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns #1 after the accept edge
  task automatic issue(int u, shift_op_e o, logic [31:0] d, logic [4:0] s);
    @(negedge clk);
    op = o;
    din = d;
    shamt = s;
    if (u == 1) start1 = 1'b1;
    else start4 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Edges until done is seen, and busy samples along the way
  task automatic wait_done(int u, output int lat, output int nb);
    lat = 0;
    nb = 0;
    while (!get_done(u) && lat < 200) begin
      if (get_busy(u)) nb++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (get_done(u)) nb++;
  endtask

  task automatic run(int u, shift_op_e o, logic [31:0] d, logic [4:0] s,
                     logic [31:0] exp, int elat, string tag);
    int lat;
    int nb;
    issue(u, o, d, s);
    wait_done(u, lat, nb);
    chk({tag, "_lat"}, 32'(lat + 1), 32'(elat));
    chk({tag, "_dout"}, get_dout(u), exp);
    chk({tag, "_busy"}, 32'(nb), 32'(elat));
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {30'd0, get_busy(u), get_done(u)}, 32'd0);
  endtask

  initial begin
    int lat;
    int nb;
    int n0;
    logic seen;

    #12;
    chk("rst_busy1", {31'd0, bus1.busy}, 32'd0);
    chk("rst_done1", {31'd0, bus1.done}, 32'd0);
    chk("rst_dout1", bus1.dout, 32'd0);
    chk("rst_dout4", bus4.dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(1, SH_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, 6, "sll4");
    run(1, SH_SRA, 32'h8000_00F0, 5'd4, 32'hF800_000F, 6, "sra4");
    run(1, SH_SRL, 32'h8000_00F0, 5'd4, 32'h0800_000F, 6, "srl4");
    run(4, SH_ROR, 32'h1234_5678, 5'd8, 32'h7812_3456, 4, "ror8");
    run(4, SH_ROR, 32'h1234_5678, 5'd0, 32'h1234_5678, 2, "ror0");
    run(4, SH_ROR, 32'h1234_5678, 5'd5, 32'hC091_A2B3, 4, "ror5");
    run(4, SH_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 10, "sra31");
    run(1, SH_SLL, 32'h0000_0003, 5'd31, 32'h8000_0000, 33, "sll31");
    run(1, SH_ROR, 32'h0000_0001, 5'd1, 32'h8000_0000, 3, "ror1");

    n0 = ndone1;
    issue(1, SH_SLL, 32'h0000_0001, 5'd3);
    @(negedge clk);
    op = SH_SRL;
    din = 32'h0000_00FF;
    shamt = 5'd1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    wait_done(1, lat, nb);
    chk("ign_lat", 32'(lat + 2), 32'd5);
    chk("ign_dout", bus1.dout, 32'h0000_0008);
    @(negedge clk);
    op = SH_SLL;
    din = 32'h0000_0055;
    shamt = 5'd0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    chk("ign_in_done", {31'd0, bus1.busy}, 32'd0);
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("acc_after_done", {31'd0, bus1.busy}, 32'd1);
    wait_done(1, lat, nb);
    chk("next_lat", 32'(lat + 1), 32'd2);
    chk("next_dout", bus1.dout, 32'h0000_0055);
    @(negedge clk);
    #1;
    chk("done_count", 32'(ndone1 - n0), 32'd2);

    issue(1, SH_SLL, 32'h0000_0003, 5'd20);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, bus1.busy}, 32'd0);
    seen = bus1.done;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus1.done) seen = 1'b1;
    end
    chk("flush_nodone", {31'd0, seen}, 32'd0);
    chk("flush_dout", bus1.dout, 32'h0000_0055);
    run(1, SH_SRL, 32'h0000_00F0, 5'd4, 32'h0000_000F, 6, "post_flush");

    issue(1, SH_SLL, 32'h0000_0001, 5'd20);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus1.busy}, 32'd0);
    chk("arst_done", {31'd0, bus1.done}, 32'd0);
    chk("arst_dout1", bus1.dout, 32'd0);
    chk("arst_dout4", bus4.dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op = SH_SLL;
    din = 32'h0000_0001;
    shamt = 5'd2;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("rel_accept", {31'd0, bus1.busy}, 32'd1);
    wait_done(1, lat, nb);
    chk("rel_lat", 32'(lat + 1), 32'd4);
    chk("rel_dout", bus1.dout, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
